vga_timing: RTL
===============

# vga_timing

Generates the 640x480 at 60 Hz raster for the display path. It divides the system clock down to the pixel rate and advances the horizontal and vertical pixel counters. It drives the active-low sync pulses, the active-video flag and a one-cycle frame-start strobe. Its `xCount`/`yCount` outputs feed every overlay generator (text, sprites, tiles) directly.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `CLK_DIV`, 2: system clocks per pixel (≥1)
- `clk`  in  1  system clock, one clock domain; all state on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `xCount`  out  10  current pixel column, 0..H_TOTAL-1 (H_TOTAL = 800)
- `yCount`  out  10  current line, 0..V_TOTAL-1 (V_TOTAL = 525)
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high while xCount < H_ACTIVE and yCount < V_ACTIVE
- `pix_tick`  out  1  high in the clk cycle before the counters advance
- `frame_start`  out  1  one-clk strobe after the counters wrap to (0,0)
- `frame_count`  out  16  number of frame_start events since reset, wraps mod 2^16

## Operation
- Divider `div`, range 0..CLK_DIV-1:
  - reset value 0; increments every clk and wraps to 0 after CLK_DIV-1.
  - `pix_tick` = (div == CLK_DIV-1), decoded from the register; with CLK_DIV = 1 it is constant 1.
- Pixel step, taken on a clk edge where pix_tick = 1:
  - xCount = H_TOTAL-1 → xCount = 0, and yCount advances (V_TOTAL-1 → 0, else +1).
  - Otherwise xCount +1 and yCount holds.
- Reset state is the last pixel of a frame: xCount = 799, yCount = 524. The first pixel step therefore lands on (0,0) and fires frame_start.
- `hsync`, `vsync` and `video_on` are registered. They are updated on the same edge as the counters, from the next-state counter values, so they always describe the current xCount/yCount.
  - hsync = 0 iff H_ACTIVE+H_FP ≤ xCount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP ≤ yCount < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- `frame_start` is registered:
  - set on the pixel-step edge whose next position is (0,0);
  - cleared on the following edge, so it is exactly 1 clk wide for any CLK_DIV.
- `frame_count` increments on the same edge that sets frame_start, and wraps 65535 → 0.
- Counter arithmetic is 10-bit unsigned. Comparisons use H_TOTAL/V_TOTAL derived from the parameters; values never exceed those totals.

## Timing
- Reset values (rst = 0, immediate, asynchronous):
  - div = 0, xCount = 799, yCount = 524
  - hsync = 1, vsync = 1, video_on = 0
  - frame_start = 0, frame_count = 0
- Reset release with CLK_DIV = 2:
  - after edge 1: pix_tick = 1.
  - after edge 2: xCount = 0, yCount = 0, video_on = 1, frame_start = 1, frame_count = 1.
  - after edge 3: frame_start = 0.
- Line period is H_TOTAL·CLK_DIV clk (1600). Frame period is H_TOTAL·V_TOTAL·CLK_DIV clk (840000).
- Output latency:
  - zero latency between xCount/yCount and hsync/vsync/video_on, since all change on the same edge;
  - downstream registered overlays see a 1-clk lag, which their own pipelining absorbs.
- Between pixel steps (pix_tick = 0) every output except frame_start holds its value.
- Simultaneous line and frame wrap at (799,524):
  - single edge: x → 0, y → 0, vsync stays 1, hsync stays 1, frame_start = 1.
- Reset asserted mid-frame:
  - all state returns to the reset values immediately, without waiting for a clk edge;
  - no frame_start is produced by the assertion;
  - after release, timing restarts exactly as from power-up.

## Test plan
- Reset release, CLK_DIV = 2:
  - checks the outputs after edges 1, 2 and 3 as listed in Timing;
  - requires reset values on all outputs while rst = 0.
- Horizontal sync, one full line from (0,10):
  - hsync falls when xCount becomes 656 and rises when xCount becomes 752;
  - video_on falls when xCount becomes 640;
  - yCount becomes 11 on the step where xCount becomes 0.
- Vertical sync and blanking:
  - vsync low only while yCount ∈ {490, 491}, for 2·1600 clk;
  - video_on = 0 for every pixel with yCount ≥ 480.
- Frame counting:
  - run 3 full frames after release;
  - frame_start pulses exactly 3 times, each 1 clk wide, 840000 clk apart;
  - frame_count = 3.
- Mid-frame reset:
  - assert rst at (300,200) for 5 clk, then release;
  - outputs return to reset values while rst is asserted;
  - next frame_start occurs 2 clk after release, with frame_count = 1.
- CLK_DIV = 1 build:
  - pix_tick is constant 1;
  - xCount advances every clk;
  - frame period is 420000 clk;
  - first frame_start 1 clk after release.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster outputs of vga_timing, shared by every overlay generator downstream.
interface vga_timing_if;
  logic [9:0]  xCount;
  logic [9:0]  yCount;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        pix_tick;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output xCount, yCount, hsync, vsync, video_on,
           pix_tick, frame_start, frame_count
  );

  modport slave (
    input xCount, yCount, hsync, vsync, video_on,
          pix_tick, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster generator: pixel-rate divider, x/y counters, registered
// sync/blanking decode and a one-clk frame-start strobe with a frame counter.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] X_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        pix_tick;
  logic [9:0]  x_count;
  logic [9:0]  y_count;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;
  logic [15:0] frame_count;

  // With a divide-by-one build there is no divider register at all.
  generate
    if (CLK_DIV > 1) begin : g_div
      logic [DIV_W-1:0] div;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          div <= '0;
        end else if (div == DIV_W'(CLK_DIV - 1)) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pix_tick = (div == DIV_W'(CLK_DIV - 1));
    end else begin : g_nodiv
      assign pix_tick = 1'b1;
    end
  endgenerate

  always_comb begin
    x_next = x_count + 10'd1;
    y_next = y_count;
    if (x_count == X_LAST) begin
      x_next = '0;
      y_next = (y_count == Y_LAST) ? 10'd0 : y_count + 10'd1;
    end
  end

  // Sync and blanking are decoded from the next position so that they change
  // on the same edge as the counters and always describe the current pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_count     <= X_LAST;
      y_count     <= Y_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        x_count  <= x_next;
        y_count  <= y_next;
        hsync    <= !((x_next >= H_SYNC_START) && (x_next < H_SYNC_END));
        vsync    <= !((y_next >= V_SYNC_START) && (y_next < V_SYNC_END));
        video_on <= (x_next < X_ACT_END) && (y_next < Y_ACT_END);
        if ((x_next == 10'd0) && (y_next == 10'd0)) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  assign vga.xCount      = x_count;
  assign vga.yCount      = y_count;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.video_on    = video_on;
  assign vga.pix_tick    = pix_tick;
  assign vga.frame_start = frame_start;
  assign vga.frame_count = frame_count;

endmodule
